pkt_tx_sched: RTL

- Packet-atomic scheduler sharing the NI transmit path (AXI write side toward the NoC local input port) between NumVC per-VC transmit buffers.
- Picks one VC by round-robin or fixed priority and forwards its head flit plus all body/tail flits before re-arbitrating. Flits from different packets never interleave.
- Output feeds the packet processor's flit request (valid/data/vc_id/pkt_sz, ready back).

---
 rtl/ravenoc_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 55 +++++
 rtl/pkt_tx_sched.sv | 137 +++++++++++++
 3 files changed

// File: rtl/ravenoc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ravenoc_pkg
// Description : Shared NI constants and the transmit-scheduler state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package ravenoc_pkg;

    localparam int c_num_virt_chn   = 3;
    localparam int c_flit_data_width = 32;
    localparam int c_pkt_width      = 8;
    localparam int c_vc_id_width    = $clog2(c_num_virt_chn);

    typedef logic [1:0] sched_state_t;

    localparam sched_state_t c_st_idle      = 2'd0;
    localparam sched_state_t c_st_head_wait = 2'd1;
    localparam sched_state_t c_st_body      = 2'd2;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational arbiter: round-robin from a pointer, or fixed
//               priority with the highest index winning.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N_REQ      = 3,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic [N_REQ-1:0]         i_req,
    input  logic [$clog2(N_REQ)-1:0] i_ptr,
    output logic [N_REQ-1:0]         o_gnt,
    output logic [$clog2(N_REQ)-1:0] o_gnt_idx,
    output logic                     o_gnt_valid
);

    localparam int c_idx_w = $clog2(N_REQ);

    int                 w_j;
    logic [c_idx_w-1:0] w_jidx;

    always_comb begin
        o_gnt       = '0;
        o_gnt_idx   = '0;
        o_gnt_valid = 1'b0;
        w_j         = 0;
        w_jidx      = '0;
        if (FIXED_PRIO) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (i_req[i]) begin
                    o_gnt_idx   = c_idx_w'(i);
                    o_gnt_valid = 1'b1;
                end
            end
        end else begin
            // First requester at or after the pointer, wrapping modulo N_REQ.
            for (int k = 0; k < N_REQ; k++) begin
                w_j = int'(i_ptr) + k;
                if (w_j >= N_REQ) begin
                    w_j = w_j - N_REQ;
                end
                w_jidx = c_idx_w'(w_j);
                if (!o_gnt_valid && i_req[w_jidx]) begin
                    o_gnt_idx   = w_jidx;
                    o_gnt_valid = 1'b1;
                end
            end
        end
        o_gnt[o_gnt_idx] = o_gnt_valid;
    end

endmodule
`default_nettype wire

// File: rtl/pkt_tx_sched.sv
`default_nettype none
// ============================================================================
// Module      : pkt_tx_sched
// Description : Packet-atomic scheduler sharing the NI transmit path between
//               per-VC buffers; a granted VC keeps the path until its tail.
// Revision    : 1.0 - initial release
// ============================================================================
module pkt_tx_sched
    import ravenoc_pkg::*;
#(
    parameter int NUM_VC          = c_num_virt_chn,
    parameter int FLIT_DATA_WIDTH = c_flit_data_width,
    parameter int PKT_WIDTH       = c_pkt_width,
    parameter bit FIXED_PRIO      = 1'b0
) (
    input  logic                              clk_axi,
    input  logic                              arst_axi,
    input  logic [NUM_VC-1:0]                 vc_valid_i,
    input  logic [NUM_VC*FLIT_DATA_WIDTH-1:0] vc_data_i,
    input  logic [NUM_VC*PKT_WIDTH-1:0]       vc_pkt_sz_i,
    output logic [NUM_VC-1:0]                 vc_ready_o,
    output logic                              out_valid_o,
    output logic [FLIT_DATA_WIDTH-1:0]        out_data_o,
    output logic [$clog2(NUM_VC)-1:0]         out_vc_id_o,
    output logic [PKT_WIDTH-1:0]              out_pkt_sz_o,
    output logic                              out_head_o,
    output logic                              out_tail_o,
    input  logic                              out_ready_i,
    output logic                              busy_o
);

    localparam int c_vc_w = $clog2(NUM_VC);

    sched_state_t         r_state;
    logic [c_vc_w-1:0]    r_grant;
    logic [c_vc_w-1:0]    r_rr_ptr;
    logic [PKT_WIDTH-1:0] r_cnt;

    logic [NUM_VC-1:0]          w_arb_gnt;
    logic [c_vc_w-1:0]          w_arb_idx;
    logic                       w_arb_valid;
    logic [c_vc_w-1:0]          w_sel;
    logic [c_vc_w-1:0]          w_sel_next;
    logic                       w_sel_valid;
    logic [FLIT_DATA_WIDTH-1:0] w_sel_data;
    logic [PKT_WIDTH-1:0]       w_sel_sz;
    logic                       w_head_phase;
    logic                       w_xfer;

    rr_arbiter #(
        .N_REQ      (NUM_VC),
        .FIXED_PRIO (FIXED_PRIO)
    ) u_arb (
        .i_req       (vc_valid_i),
        .i_ptr       (r_rr_ptr),
        .o_gnt       (w_arb_gnt),
        .o_gnt_idx   (w_arb_idx),
        .o_gnt_valid (w_arb_valid)
    );

    // Outside IDLE the path is pinned to the latched grant so a stalled head
    // cannot be swapped for a newly arriving requester.
    always_comb begin
        w_head_phase = (r_state != c_st_body);
        w_sel        = (r_state == c_st_idle) ? w_arb_idx : r_grant;
        w_sel_valid  = (r_state == c_st_idle) ? w_arb_valid : vc_valid_i[w_sel];
        w_sel_data   = vc_data_i[int'(w_sel)*FLIT_DATA_WIDTH +: FLIT_DATA_WIDTH];
        w_sel_sz     = vc_pkt_sz_i[int'(w_sel)*PKT_WIDTH +: PKT_WIDTH];
        w_sel_next   = (w_sel == c_vc_w'(NUM_VC-1)) ? '0 : w_sel + 1'b1;
        w_xfer       = w_sel_valid && out_ready_i;

        out_valid_o  = w_sel_valid;
        out_vc_id_o  = w_sel;
        out_data_o   = w_sel_valid ? w_sel_data : '0;
        out_head_o   = w_head_phase && w_sel_valid;
        out_pkt_sz_o = (w_head_phase && w_sel_valid) ? w_sel_sz : '0;
        out_tail_o   = w_head_phase ? (w_sel_valid && (w_sel_sz == '0))
                                    : (r_cnt == PKT_WIDTH'(1));
        busy_o       = (r_state != c_st_idle);

        vc_ready_o   = '0;
        if (w_xfer) begin
            vc_ready_o[w_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk_axi or posedge arst_axi) begin
        if (arst_axi) begin
            r_state  <= c_st_idle;
            r_grant  <= '0;
            r_cnt    <= '0;
            r_rr_ptr <= '0;
        end else begin
            case (r_state)
                c_st_idle, c_st_head_wait: begin
                    if ((r_state == c_st_head_wait) && !vc_valid_i[r_grant]) begin
                        r_state <= c_st_idle;
                    end else if (w_xfer) begin
                        if (w_sel_sz == '0) begin
                            r_state  <= c_st_idle;
                            r_rr_ptr <= w_sel_next;
                        end else begin
                            r_state <= c_st_body;
                            r_grant <= w_sel;
                            r_cnt   <= w_sel_sz;
                        end
                    end else if (w_sel_valid) begin
                        r_state <= c_st_head_wait;
                        r_grant <= w_sel;
                    end
                end
                c_st_body: begin
                    if (w_xfer) begin
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == PKT_WIDTH'(1)) begin
                            r_state  <= c_st_idle;
                            r_rr_ptr <= w_sel_next;
                        end
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    a_ready_onehot0 : assert property (@(posedge clk_axi) disable iff (arst_axi)
        $onehot0(vc_ready_o));

    a_stall_stable : assert property (@(posedge clk_axi) disable iff (arst_axi)
        (out_valid_o && !out_ready_i) |=> (!out_valid_o ||
            ($stable(out_vc_id_o) && $stable(out_data_o) && $stable(out_head_o) &&
             $stable(out_tail_o) && $stable(out_pkt_sz_o))));

endmodule
`default_nettype wire
